machine_timer: RTL and testbench

- Memory-mapped RISC-V machine timer, 64-bit mtime / mtimecmp. Sits directly upstream of the CSR block.
- Its registered active-LOW output ti drives the CSR timer-interrupt input, which sets mip[7].
- Software programs it through a simple word-wide load/store port. Single clock domain, shared with the core.

---
 rtl/mtimer_pkg.sv | 29 ++
 rtl/mtimer_prescaler.sv | 42 ++++
 rtl/machine_timer.sv | 130 +++++++++++++
 tb/tb_machine_timer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mtimer_pkg.sv
// Shared definitions for the RISC-V machine timer: register offsets,
// CTRL bit layout and 64-bit reset constants.
package mtimer_pkg;

    // Word offset on the load/store port (byte address bits [4:2]).
    typedef logic [2:0] reg_addr_t;

    localparam reg_addr_t MTIME_LO    = 3'd0;
    localparam reg_addr_t MTIME_HI    = 3'd1;
    localparam reg_addr_t MTIMECMP_LO = 3'd2;
    localparam reg_addr_t MTIMECMP_HI = 3'd3;
    localparam reg_addr_t MTIMER_CTRL = 3'd4;

    // CTRL register layout: only the run bit exists.
    localparam int CTRL_RUN_BIT = 0;

    // 64-bit reset constants.
    localparam logic [63:0] MTIME_RST            = 64'h0000_0000_0000_0000;
    localparam logic [63:0] MTIMECMP_RST_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

    // Read-back image of CTRL: run in its bit position, all other bits zero.
    function automatic logic [31:0] ctrl_word(input logic run);
        logic [31:0] w;
        w = 32'h0;
        w[CTRL_RUN_BIT] = run;
        return w;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for the machine timer: divides the core clock by PRESCALE and
// emits a one-cycle tick each time mtime should advance. The counter holds
// while run is low and is cleared by clr (a CTRL write).
module mtimer_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    // PRESCALE=1 still needs a one-bit counter; it simply never leaves 0.
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // Tick is combinational on the current count so mtime advances on the
    // same edge the counter wraps.
    assign tick = run && (cnt == LAST);

    // Count 0..PRESCALE-1 while running; hold when stopped; clear on CTRL write.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped RISC-V machine timer (mtime / mtimecmp) with a word-wide
// load/store port and a registered active-low timer interrupt ti feeding the
// CSR block (mip[7]).
// Optional build macro MTIMER_SNAPSHOT_EN: a read of mtime lo latches mtime hi
// into a shadow, and reads of mtime hi return that shadow for an atomic
// lo-then-hi 64-bit read.
module machine_timer
    import mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE     = 4,
    parameter logic [63:0] MTIMECMP_RST = MTIMECMP_RST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wen,
    input  logic        ren,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ti
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        run;
    logic        tick;
    logic        wr;
    logic        rd;
    logic [31:0] rd_word;

    assign wr = en && wen;
    assign rd = en && ren;

    mtimer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clr  (wr && (addr == MTIMER_CTRL)),
        .tick (tick)
    );

    // CTRL.run: written from wdata bit 0, other bits discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
        end else if (wr && (addr == MTIMER_CTRL)) begin
            run <= wdata[CTRL_RUN_BIT];
        end
    end

    // mtime: a software write to either half wins over the tick increment,
    // so the whole 64-bit value skips the increment in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= MTIME_RST;
        end else if (wr && (addr == MTIME_LO)) begin
            mtime[31:0] <= wdata;
        end else if (wr && (addr == MTIME_HI)) begin
            mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp: halves written independently; software orders the writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= MTIMECMP_RST;
        end else if (wr && (addr == MTIMECMP_LO)) begin
            mtimecmp[31:0] <= wdata;
        end else if (wr && (addr == MTIMECMP_HI)) begin
            mtimecmp[63:32] <= wdata;
        end
    end

    // Level-sensitive interrupt: low while mtime >= mtimecmp, one cycle late.
    always_ff @(posedge clk) begin
        if (rst) begin
            ti <= 1'b1;
        end else begin
            ti <= ~(mtime >= mtimecmp);
        end
    end

`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0] mtime_hi_shadow;

    // Capture mtime hi alongside every mtime lo read.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_hi_shadow <= 32'h0;
        end else if (rd && (addr == MTIME_LO)) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end
`endif

    // Read mux over pre-edge register values, so a same-cycle write to the
    // addressed register is not visible in this read.
    always_comb begin
        // NOTE: default assignment first keeps this block free of latches
        // for any address not covered below.
        rd_word = 32'h0;
        case (addr)
            MTIME_LO:    rd_word = mtime[31:0];
`ifdef MTIMER_SNAPSHOT_EN
            MTIME_HI:    rd_word = mtime_hi_shadow;
`else
            MTIME_HI:    rd_word = mtime[63:32];
`endif
            MTIMECMP_LO: rd_word = mtimecmp[31:0];
            MTIMECMP_HI: rd_word = mtimecmp[63:32];
            MTIMER_CTRL: rd_word = ctrl_word(run);
            default:     rd_word = 32'h0;
        endcase
    end

    // Registered read data, held until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'h0;
        end else if (rd) begin
            rdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Directed self-checking bench for machine_timer (PRESCALE=4). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_machine_timer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        wen;
    logic        ren;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ti;

    int checks   = 0;
    int failures = 0;

    machine_timer #(
        .PRESCALE     (4),
        .MTIMECMP_RST (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .wen   (wen),
        .ren   (ren),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ti    (ti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; write lands on the next rising edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        en = 1'b1; wen = 1'b1; ren = 1'b0; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b0; wen = 1'b0;
    endtask

    // Called at a falling edge; returns the word captured on the next rising edge.
    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        en = 1'b1; ren = 1'b1; wen = 1'b0; addr = a;
        @(negedge clk);
        en = 1'b0; ren = 1'b0;
        d = rdata;
    endtask

    logic [31:0] r;
    logic [31:0] exp_hi;

    initial begin
        rst = 1'b1; en = 1'b0; wen = 1'b0; ren = 1'b0; addr = 3'd0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and idle with run=0.
        repeat (20) @(negedge clk);
        check("idle_rdata", rdata, 32'h0);
        check("idle_ti", {31'h0, ti}, 32'h1);
        bus_read(3'd0, r); check("idle_mtime_lo", r, 32'h0);
        bus_read(3'd1, r); check("idle_mtime_hi", r, 32'h0);
        bus_read(3'd2, r); check("rst_cmp_lo", r, 32'hFFFF_FFFF);
        bus_read(3'd3, r); check("rst_cmp_hi", r, 32'hFFFF_FFFF);
        bus_read(3'd4, r); check("rst_ctrl", r, 32'h0);

        // Run for 40 cycles at PRESCALE=4: increments on edges 4,8,..,40.
        bus_write(3'd4, 32'h1);
        repeat (40) @(negedge clk);
        bus_read(3'd0, r); check("run40_mtime_lo", r, 32'd10);
        bus_read(3'd1, r); check("run40_mtime_hi", r, 32'd0);

        // Compare: mtimecmp=5, ti falls one cycle after mtime reaches 5.
        bus_write(3'd4, 32'h0);
        bus_write(3'd0, 32'h0);
        bus_write(3'd3, 32'h0);
        bus_write(3'd2, 32'd5);
        bus_write(3'd4, 32'h1);
        repeat (20) @(negedge clk);
        check("cmp_ti_at_match", {31'h0, ti}, 32'h1);
        @(negedge clk);
        check("cmp_ti_after_match", {31'h0, ti}, 32'h0);
        bus_read(3'd0, r); check("cmp_mtime_lo", r, 32'd5);
        bus_write(3'd2, 32'd100);
        check("cmp_ti_still_low", {31'h0, ti}, 32'h0);
        @(negedge clk);
        check("cmp_ti_released", {31'h0, ti}, 32'h1);

        // Carry from lo into hi, then a write in a tick cycle.
        bus_write(3'd4, 32'h0);
        bus_write(3'd3, 32'hFFFF_FFFF);
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_write(3'd1, 32'h0);
        bus_write(3'd4, 32'h1);
        repeat (4) @(negedge clk);
        bus_read(3'd1, r); check("carry_mtime_hi", r, 32'd1);
        bus_read(3'd0, r); check("carry_mtime_lo", r, 32'd0);
        @(negedge clk);
        bus_write(3'd0, 32'h0000_1234);
        bus_read(3'd0, r); check("tickwr_mtime_lo", r, 32'h0000_1234);
        bus_read(3'd1, r); check("tickwr_mtime_hi", r, 32'd1);
        check("carry_ti_high", {31'h0, ti}, 32'h1);

        // Reset while ti is low and the timer is running.
        bus_write(3'd3, 32'h0);
        repeat (2) @(negedge clk);
        check("pre_rst_ti", {31'h0, ti}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ti", {31'h0, ti}, 32'h1);
        check("mid_rst_rdata", rdata, 32'h0);
        bus_read(3'd0, r); check("mid_rst_mtime_lo", r, 32'h0);
        bus_read(3'd1, r); check("mid_rst_mtime_hi", r, 32'h0);
        bus_read(3'd2, r); check("mid_rst_cmp_lo", r, 32'hFFFF_FFFF);
        bus_read(3'd3, r); check("mid_rst_cmp_hi", r, 32'hFFFF_FFFF);
        bus_read(3'd4, r); check("mid_rst_ctrl", r, 32'h0);

        // Lo-then-hi read straddling the carry at mtime=0000_0000_FFFF_FFFF.
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_write(3'd4, 32'h1);
        @(negedge clk);
        bus_read(3'd0, r); check("snap_mtime_lo", r, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
`ifdef MTIMER_SNAPSHOT_EN
        exp_hi = 32'd0;
`else
        exp_hi = 32'd1;
`endif
        bus_read(3'd1, r); check("snap_mtime_hi", r, exp_hi);
        bus_read(3'd0, r); check("snap_live_lo", r, 32'd0);

        // CTRL reads only bit 0; unmapped offsets read 0 and ignore writes.
        bus_write(3'd4, 32'hFFFF_FFFF);
        bus_read(3'd4, r); check("ctrl_mask", r, 32'h1);
        bus_write(3'd5, 32'hDEAD_BEEF);
        bus_read(3'd5, r); check("unmapped_5", r, 32'h0);
        bus_read(3'd7, r); check("unmapped_7", r, 32'h0);

        // Simultaneous read and write of the same register returns the old value.
        en = 1'b1; ren = 1'b1; wen = 1'b1; addr = 3'd2; wdata = 32'h0000_1111;
        @(negedge clk);
        en = 1'b0; ren = 1'b0; wen = 1'b0;
        check("rw_same_addr_old", rdata, 32'hFFFF_FFFF);
        bus_read(3'd2, r); check("rw_same_addr_new", r, 32'h0000_1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
